// File: rtl/calc_result_formatter_if.sv
// Result-in / ASCII-byte-out bus of the calculator result formatter.
// The slave modport is the formatter; the master modport is the surrounding system.
interface calc_result_formatter_if;
  logic signed [31:0] calc_res;
  logic               calc_done;
  logic        [7:0]  tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic               format_done;

  modport master (
    output calc_res, calc_done, tx_ready,
    input  tx_data, tx_valid, busy, format_done
  );

  modport slave (
    input  calc_res, calc_done, tx_ready,
    output tx_data, tx_valid, busy, format_done
  );
endinterface

// File: rtl/calc_result_formatter.sv
// Converts a signed 32-bit calculator result to ASCII decimal using serial double-dabble.
// Streams the result over a valid/ready byte interface, optionally terminated with CR LF.
module calc_result_formatter #(
  parameter int unsigned TERM_CRLF = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  calc_result_formatter_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_SIGN, S_DIGIT, S_CR, S_LF, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        neg_q, neg_d;
  logic [31:0] mag_q, mag_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [71:0] dd_shift;
  logic [3:0]  cur_nib;
  logic [7:0]  tx_data;
  logic        tx_valid;

  function automatic logic [39:0] dabble_adj(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Index of the most-significant nonzero digit; 0 when the value is zero.
  function automatic logic [3:0] msd_index(input logic [39:0] b);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (b[i*4 +: 4] != 4'd0) idx = 4'(i);
    end
    return idx;
  endfunction

  assign cur_nib = bcd_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    state_d  = state_q;
    neg_d    = neg_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dd_shift = {dabble_adj(bcd_q), mag_q} << 1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io.calc_done) begin
          neg_d   = io.calc_res[31];
          mag_d   = io.calc_res[31] ? (~io.calc_res + 32'd1) : io.calc_res;
          bcd_d   = 40'd0;
          cnt_d   = 5'd0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = dd_shift[71:32];
        mag_d = dd_shift[31:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          // The digit index is taken from the final BCD value being loaded this edge.
          idx_d   = msd_index(dd_shift[71:32]);
          state_d = neg_q ? S_SIGN : S_DIGIT;
        end
      end
      S_SIGN: begin
        tx_valid = 1'b1;
        tx_data  = 8'h2D;
        if (io.tx_ready) state_d = S_DIGIT;
      end
      S_DIGIT: begin
        tx_valid = 1'b1;
        tx_data  = 8'h30 + {4'h0, cur_nib};
        if (io.tx_ready) begin
          if (idx_q == 4'd0) state_d = (TERM_CRLF != 0) ? S_CR : S_DONE;
          else               idx_d   = idx_q - 4'd1;
        end
      end
      S_CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (io.tx_ready) state_d = S_LF;
      end
      S_LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (io.tx_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcd_q   <= 40'd0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
    end
  end

  always_ff @(posedge clk) begin
    neg_q <= neg_d;
    mag_q <= mag_d;
    cnt_q <= cnt_d;
    idx_q <= idx_d;
  end

  assign io.tx_data     = tx_data;
  assign io.tx_valid    = tx_valid;
  assign io.busy        = (state_q != S_IDLE);
  assign io.format_done = (state_q == S_DONE);

endmodule

// File: tb/tb_calc_result_formatter.sv
// Bench for calc_result_formatter: directed table, hand-written reset sequence and
// randomized results checked against a decimal-string reference model.
module tb_calc_result_formatter;

  logic clk = 1'b0;
  logic rst;

  calc_result_formatter_if bus();

  calc_result_formatter #(.TERM_CRLF(1)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    string       text;
    int          pct;
    bit          inject;
  } vec_t;

  vec_t vecs[$];
  byte  exp_q[$];
  byte  got_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] v, input string s, input int pct, input bit inj);
    vec_t e;
    e.val = v; e.text = s; e.pct = pct; e.inject = inj;
    vecs.push_back(e);
  endtask

  // Expected byte stream straight from the decimal value of the result.
  function automatic void build_model(input logic [31:0] v);
    longint m;
    byte    d[$];
    exp_q.delete();
    m = longint'($signed(v));
    if (m < 0) begin
      exp_q.push_back(8'h2D);
      m = -m;
    end
    do begin
      d.push_front(8'h30 + byte'(m % 10));
      m = m / 10;
    end while (m > 0);
    foreach (d[i]) exp_q.push_back(d[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic void build_from_text(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // Entered and left one step after an edge, with the DUT idle.
  task automatic run_one(input logic [31:0] val, input int pct, input bit inject, input string tag);
    int  k, first, last;
    bit  done, injected, pv, pr, rdy;
    byte pd;
    got_q.delete();
    bus.calc_res  = val;
    bus.calc_done = 1'b1;
    tick();
    bus.calc_done = 1'b0;
    k = 1;
    check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    first = -1; last = -1; done = 0; injected = 0; pv = 0; pr = 0; pd = 8'h00;
    while (k < 600) begin
      rdy = ($urandom_range(0, 99) < pct);
      bus.tx_ready = rdy;
      if (inject && !injected && got_q.size() == 2) begin
        bus.calc_res  = 32'd99;
        bus.calc_done = 1'b1;
        injected = 1;
      end else begin
        bus.calc_done = 1'b0;
      end
      if (pv && !pr) begin
        check({tag, "_stall_valid"}, 32'(bus.tx_valid), 32'd1);
        check({tag, "_stall_data"}, 32'(bus.tx_data), 32'(pd));
      end
      if (bus.tx_valid && first < 0) first = k;
      if (bus.format_done) begin
        done = 1;
        break;
      end
      if (bus.tx_valid && rdy) begin
        got_q.push_back(bus.tx_data);
        last = k;
      end
      pv = bus.tx_valid; pr = rdy; pd = bus.tx_data;
      tick();
      k++;
    end
    bus.calc_done = 1'b0;
    check({tag, "_format_done_seen"}, 32'(done), 32'd1);
    check({tag, "_first_valid_cycle"}, 32'(first), 32'd33);
    check({tag, "_format_done_cycle"}, 32'(k), 32'(last + 1));
    check({tag, "_byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check({tag, $sformatf("_byte%0d", i)}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    tick();
    check({tag, "_busy_after_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_format_done_pulse"}, 32'(bus.format_done), 32'd0);
  endtask

  initial begin
    logic [31:0] rv;
    int k;

    add_vec(32'h0000_0000, "0",           100, 0);
    add_vec(32'h0000_04D2, "1234",        100, 0);
    add_vec(32'hFFFF_FFFB, "-5",          100, 0);
    add_vec(32'h8000_0000, "-2147483648", 100, 0);
    add_vec(32'h7FFF_FFFF, "2147483647",  100, 0);
    add_vec(32'h0000_04D2, "1234",        40,  1);

    rst = 1'b1;
    bus.calc_res = 32'd0; bus.calc_done = 1'b0; bus.tx_ready = 1'b0;
    repeat (3) tick();
    check("reset_tx_data",     32'(bus.tx_data),     32'h00);
    check("reset_tx_valid",    32'(bus.tx_valid),    32'd0);
    check("reset_busy",        32'(bus.busy),        32'd0);
    check("reset_format_done", 32'(bus.format_done), 32'd0);
    rst = 1'b0;
    tick();

    // Back-to-back runs: each new result starts the cycle after busy falls.
    foreach (vecs[i]) begin
      build_from_text(vecs[i].text);
      run_one(vecs[i].val, vecs[i].pct, vecs[i].inject, $sformatf("vec%0d", i));
    end

    // Reset while the third byte of 1234 is stalled.
    bus.calc_res = 32'd1234; bus.calc_done = 1'b1; bus.tx_ready = 1'b0;
    tick();
    bus.calc_done = 1'b0;
    k = 0;
    while (!bus.tx_valid && k < 100) begin
      tick();
      k++;
    end
    check("rst_seq_valid_seen", 32'(bus.tx_valid), 32'd1);
    bus.tx_ready = 1'b1;
    repeat (2) tick();
    bus.tx_ready = 1'b0;
    tick();
    check("rst_seq_third_byte", 32'(bus.tx_data), 32'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_seq_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_seq_busy",     32'(bus.busy),     32'd0);
    check("rst_seq_tx_data",  32'(bus.tx_data),  32'h00);
    build_model(32'd7);
    run_one(32'd7, 100, 0, "after_rst");

    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 1) rv = 32'($urandom_range(0, 2000)) - 32'd1000;
      else            rv = $urandom;
      build_model(rv);
      run_one(rv, $urandom_range(20, 100), i % 3 == 0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_result_formatter.md
# calc_result_formatter

- Converts a 32-bit two's-complement result from a calculator operation unit into an ASCII decimal string.
- Streams the string one byte at a time to the UART transmitter.
- Sits between the arithmetic units (add/subtract/multiply, which pulse a done flag alongside `calc_res`) and the UART TX byte interface.
- It is the consuming end of the calculator result interface.

## Interface
Parameters
- `TERM_CRLF`, 1, when 1 append CR (0x0D) LF (0x0A) after the digits; when 0 append nothing.

Ports
- `clk`  in  1  single clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `calc_res`  in  32  signed result, sampled only on the cycle `calc_done`=1.
- `calc_done`  in  1  one-cycle pulse from the operation unit: result valid.
- `tx_data`  out  8  ASCII byte to the UART TX.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  UART TX accepts the byte this cycle.
- `busy`  out  1  conversion or transmission in progress.
- `format_done`  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- States: IDLE, CONV, SIGN, DIGIT, CR, LF, DONE.
- IDLE, `calc_done`=1:
  - Latch `neg`=`calc_res[31]`.
  - Latch magnitude = `neg` ? (~`calc_res`+1) : `calc_res`, as 32-bit unsigned. 0x80000000 yields 2147483648.
  - Clear a 40-bit BCD register (10 digits), load shift count 0, go to CONV.
- CONV: double-dabble, one bit per cycle for 32 cycles.
  - Each cycle, add 3 to every BCD nibble ≥5, then shift {BCD, magnitude} left 1.
  - After the 32nd shift go to SIGN if `neg`, else DIGIT.
- Digit index is set on entry to DIGIT:
  - It is the most-significant nonzero nibble, via a combinational priority encoder over the BCD register.
  - If all nibbles are zero, the index is 0, so the output is a single '0'.
- SIGN: present '-' (0x2D). On accept go to DIGIT.
- DIGIT: present 0x30+nibble[index].
  - On accept, if index==0 go to CR (TERM_CRLF=1) or DONE (TERM_CRLF=0); else decrement index.
- CR: present 0x0D; on accept go to LF. LF: present 0x0A; on accept go to DONE.
- DONE: `format_done`=1 for one cycle, then IDLE.
- Handshake:
  - A byte is transferred on a cycle with `tx_valid`=1 and `tx_ready`=1.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` holds stable and `tx_valid` stays high.
  - `tx_valid` never drops without a transfer except on reset.
- `calc_done` outside IDLE (including in DONE) is ignored. No queueing; that result is lost.
- `tx_ready` outside SIGN/DIGIT/CR/LF has no effect.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: `tx_data`=0x00, `tx_valid`=0, `busy`=0, `format_done`=0, state IDLE, BCD register cleared.
- Reset applied mid-conversion or mid-transmission:
  - Aborts immediately; outputs take their reset values the next cycle.
  - A partially sent string is not completed.
- `calc_done` is sampled at edge E0. `busy`=1 from the cycle after E0.
- CONV occupies the 32 cycles after E0. `tx_valid` first rises 33 cycles after the `calc_done` cycle.
- With `tx_ready` held at 1, one byte transfers per cycle; `tx_valid` stays high across consecutive bytes.
- `format_done` is high the cycle after the LF transfer (or the last-digit transfer if TERM_CRLF=0). `busy` is 0 the cycle after that.
- Minimum turnaround: a new `calc_done` is accepted the cycle after `format_done`.
- Byte count = sign(0/1) + digits(1..10) + 2·TERM_CRLF. The maximum is 13 bytes, for 0x80000000.

## Test plan
- `calc_res`=0x00000000, `tx_ready`=1 -> bytes 0x30,0x0D,0x0A.
  - First `tx_valid` 33 cycles after `calc_done`; `format_done` one cycle after 0x0A.
- `calc_res`=0x000004D2 (1234) -> '1','2','3','4',CR,LF on consecutive cycles; no leading zeros.
- `calc_res`=0xFFFFFFFB (-5, e.g. 3-8 from the subtract unit) -> '-','5',CR,LF.
- `calc_res`=0x80000000 -> "-2147483648" then CR,LF (13 bytes).
  - Also `calc_res`=0x7FFFFFFF -> "2147483647" then CR,LF.
- 1234 with `tx_ready` toggling pseudo-randomly (≥50% low) -> same byte sequence.
  - `tx_data` is stable during every stall.
  - A second `calc_done` (value 99) pulsed mid-stream is ignored; no extra bytes.
- Assert `rst` for one cycle while the third byte of 1234 is stalled -> next cycle `tx_valid`=0, `busy`=0.
  - A subsequent `calc_done` with 7 yields exactly '7',CR,LF.
